primogen_wide: RTL

Parametrised prime-number generator: the successor to the fixed 16-bit `primogen`, with configurable result width, a seeded-search mode and a saturating prime counter. On each accepted `go` it searches for the next prime by trial division with iterative subtraction; no hardware divider or multiplier. It sits behind the same `go`/`ready`/`error` handshake, so existing benches drive it unchanged when `mode` is tied to 0.

---
 rtl/primogen_wide.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/primogen_wide.sv
// primogen_wide: parametrised next-prime generator.
// Trial division by repeated subtraction (no divider/multiplier). Odd
// divisors d = 3, 5, 7, ... are tried while d*d <= candidate. d*d is kept
// incrementally in sq via (d+2)^2 = d^2 + 4d + 4.
module primogen_wide #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     seed,
    output logic [WIDTH-1:0]     res,
    output logic                 ready,
    output logic                 error,
    output logic [CNT_WIDTH-1:0] count
);

    localparam int CW = WIDTH + 1;  // candidate / remainder width (carries overflow bit)
    localparam int SW = WIDTH + 2;  // running square width

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_TEST, S_DIV, S_BUMP, S_DONE_OK, S_DONE_ERR
    } state_t;

    state_t               state, state_n;
    logic                 mode_q, mode_n;
    logic [WIDTH-1:0]     seed_q, seed_n;
    logic [CW-1:0]        cand, cand_n;
    logic [CW-1:0]        r, r_n;
    logic [WIDTH-1:0]     d, d_n;
    logic [SW-1:0]        sq, sq_n;
    logic [WIDTH-1:0]     res_n;
    logic                 error_n;
    logic [CNT_WIDTH-1:0] count_n;

    logic [CW-1:0]        start_cand;
    logic [CW-1:0]        cand_p2;
    logic [CW-1:0]        d_ext;
    logic [SW:0]          sq_sum;
    logic [SW-1:0]        sq_sat;

    assign ready = (state == S_IDLE);

    // Datapath helpers: starting candidate, +2 step, and the saturating
    // next-square so a large d can never wrap sq below the candidate.
    always_comb begin
        start_cand = '0;
        if (!mode_q) begin
            if (res < WIDTH'(3))
                start_cand = CW'(res) + CW'(1);
            else
                start_cand = CW'(res) + CW'(2);
        end else begin
            if (seed_q <= WIDTH'(2))
                start_cand = CW'(2);
            else
                start_cand = CW'(seed_q) + CW'(!seed_q[0]);
        end
        cand_p2 = cand + CW'(2);
        d_ext   = CW'(d);
        sq_sum  = (SW+1)'(sq) + (SW+1)'({d, 2'b00}) + (SW+1)'(4);
        sq_sat  = sq_sum[SW] ? {SW{1'b1}} : sq_sum[SW-1:0];
    end

    // Next-state and next-register logic for the search FSM.
    always_comb begin
        state_n = state;
        mode_n  = mode_q;
        seed_n  = seed_q;
        cand_n  = cand;
        r_n     = r;
        d_n     = d;
        sq_n    = sq;
        res_n   = res;
        error_n = error;
        count_n = count;
        case (state)
            S_IDLE: begin
                if (go) begin
                    mode_n  = mode;
                    seed_n  = seed;
                    state_n = S_START;
                end
            end
            S_START: begin
                cand_n = start_cand;
                if (start_cand[WIDTH]) begin
                    state_n = S_DONE_ERR;
                end else if (start_cand == CW'(2) || start_cand == CW'(3)) begin
                    state_n = S_DONE_OK;
                end else begin
                    d_n     = WIDTH'(3);
                    sq_n    = SW'(9);
                    state_n = S_TEST;
                end
            end
            S_TEST: begin
                if (sq > SW'(cand)) begin
                    state_n = S_DONE_OK;
                end else begin
                    r_n     = cand;
                    state_n = S_DIV;
                end
            end
            S_DIV: begin
                if (r >= d_ext) begin
                    r_n = r - d_ext;
                end else if (r == '0) begin
                    // d divides the candidate: move to the next odd one
                    cand_n  = cand_p2;
                    state_n = cand_p2[WIDTH] ? S_DONE_ERR : S_BUMP;
                end else begin
                    sq_n    = sq_sat;
                    d_n     = d + WIDTH'(2);
                    state_n = S_TEST;
                end
            end
            S_BUMP: begin
                d_n     = WIDTH'(3);
                sq_n    = SW'(9);
                state_n = S_TEST;
            end
            S_DONE_OK: begin
                res_n   = cand[WIDTH-1:0];
                error_n = 1'b0;
                if (!(&count))
                    count_n = count + CNT_WIDTH'(1);
                state_n = S_IDLE;
            end
            S_DONE_ERR: begin
                error_n = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State and datapath registers; async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            mode_q <= 1'b0;
            seed_q <= '0;
            cand   <= '0;
            r      <= '0;
            d      <= WIDTH'(3);
            sq     <= SW'(9);
            res    <= WIDTH'(1);
            error  <= 1'b0;
            count  <= '0;
        end else begin
            state  <= state_n;
            mode_q <= mode_n;
            seed_q <= seed_n;
            cand   <= cand_n;
            r      <= r_n;
            d      <= d_n;
            sq     <= sq_n;
            res    <= res_n;
            error  <= error_n;
            count  <= count_n;
        end
    end

endmodule
